// File: rtl/kb_key_tracker_if.sv
// rtl/kb_key_tracker_if.sv - scancode byte stream from the PS/2 byte receiver
// Ports (signals):
//   data   8  received scancode byte, stable while valid is high
//   valid  1  byte-available level; a rising edge marks one new byte
// Modports: master drives the stream (receiver side), slave consumes it (tracker side).
interface kb_key_tracker_if;
  logic [7:0] data;
  logic       valid;

  modport master (output data, output valid);
  modport slave  (input data, input valid);
endinterface

// File: rtl/kb_key_tracker.sv
// rtl/kb_key_tracker.sv - tracks left/right/fire key state from a PS/2 scancode stream
// Ports:
//   clk         in   1  system clock
//   reset       in   1  asynchronous active-high reset
//   kb          in   -  scancode stream (kb_key_tracker_if.slave: data, valid)
//   user_move   out  2  01 right, 10 left, 00 none
//   fire        out  1  fire key held
//   fire_pulse  out  1  one-cycle strobe when fire goes from released to held
//   left_held   out  1  left or left-arrow held
//   right_held  out  1  right or right-arrow held
module kb_key_tracker #(
  parameter logic [7:0] KEY_LEFT       = 8'h1C,
  parameter logic [7:0] KEY_RIGHT      = 8'h23,
  parameter logic [7:0] KEY_FIRE       = 8'h29,
  parameter logic [7:0] KEY_XLEFT      = 8'h6B,
  parameter logic [7:0] KEY_XRIGHT     = 8'h74,
  parameter int         TIMEOUT_CYCLES = 2_500_000
) (
  input  logic                clk,
  input  logic                reset,
  kb_key_tracker_if.slave     kb,
  output logic [1:0]          user_move,
  output logic                fire,
  output logic                fire_pulse,
  output logic                left_held,
  output logic                right_held
);

  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam int         CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t          state, state_next;
  logic            valid_q;
  logic            accept;
  logic            is_brk, is_ext;
  logic            timeout_hit;
  logic [CW-1:0]   cnt;

  logic            do_make, do_break, use_ext_table;
  logic            hit_left, hit_right, hit_fire;

  logic            left_r, right_r, fire_r, last_dir;
  logic [1:0]      move_next;

  // A byte counts once per rising edge of valid, however long valid stays high.
  assign accept = kb.valid & ~valid_q;
  assign is_brk = (kb.data == CODE_BRK);
  assign is_ext = (kb.data == CODE_EXT);

  // An incoming byte takes priority over the timeout firing in the same cycle.
  assign timeout_hit = (state != S_IDLE) && !accept && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= kb.valid;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (accept) begin
      case (state)
        S_IDLE: begin
          if (is_brk)      state_next = S_BRK;
          else if (is_ext) state_next = S_EXT;
          else             state_next = S_IDLE;
        end
        S_EXT: begin
          if (is_brk)      state_next = S_EXT_BRK;
          else if (is_ext) state_next = S_EXT;
          else             state_next = S_IDLE;
        end
        // A prefix byte after a break prefix is malformed; drop back to IDLE.
        S_BRK:     state_next = S_IDLE;
        S_EXT_BRK: state_next = S_IDLE;
        default:   state_next = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_next = S_IDLE;
    end
  end

  // Output (action) logic
  always_comb begin
    do_make       = 1'b0;
    do_break      = 1'b0;
    use_ext_table = 1'b0;
    if (accept && !is_brk && !is_ext) begin
      case (state)
        S_IDLE:    do_make  = 1'b1;
        S_BRK:     do_break = 1'b1;
        S_EXT: begin
          do_make       = 1'b1;
          use_ext_table = 1'b1;
        end
        S_EXT_BRK: begin
          do_break      = 1'b1;
          use_ext_table = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Fire has no extended alias, so it only matches the plain table.
  always_comb begin
    hit_left  = use_ext_table ? (kb.data == KEY_XLEFT)  : (kb.data == KEY_LEFT);
    hit_right = use_ext_table ? (kb.data == KEY_XRIGHT) : (kb.data == KEY_RIGHT);
    hit_fire  = !use_ext_table && (kb.data == KEY_FIRE);
  end

  // Prefix wait counter; only runs outside IDLE and saturates at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept || state_next == S_IDLE) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Held-key state. last_dir: 0 = left, 1 = right; typematic makes refresh it too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_r   <= 1'b0;
      right_r  <= 1'b0;
      fire_r   <= 1'b0;
      last_dir <= 1'b0;
    end else if (do_make) begin
      if (hit_left) begin
        left_r   <= 1'b1;
        last_dir <= 1'b0;
      end
      if (hit_right) begin
        right_r  <= 1'b1;
        last_dir <= 1'b1;
      end
      if (hit_fire) fire_r <= 1'b1;
    end else if (do_break) begin
      if (hit_left)  left_r  <= 1'b0;
      if (hit_right) right_r <= 1'b0;
      if (hit_fire)  fire_r  <= 1'b0;
    end
  end

  always_comb begin
    move_next = 2'b00;
    if (left_r && right_r) move_next = last_dir ? 2'b01 : 2'b10;
    else if (left_r)       move_next = 2'b10;
    else if (right_r)      move_next = 2'b01;
  end

  // Registered outputs, one cycle behind the held-key state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      user_move  <= 2'b00;
      fire       <= 1'b0;
      fire_pulse <= 1'b0;
      left_held  <= 1'b0;
      right_held <= 1'b0;
    end else begin
      user_move  <= move_next;
      fire       <= fire_r;
      fire_pulse <= fire_r & ~fire;
      left_held  <= left_r;
      right_held <= right_r;
    end
  end

endmodule

// File: tb/tb_kb_key_tracker.sv
// tb/tb_kb_key_tracker.sv - self-checking bench for kb_key_tracker
module tb_kb_key_tracker;
  localparam int T = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] user_move;
  logic       fire, fire_pulse, left_held, right_held;

  kb_key_tracker_if kb_if ();

  kb_key_tracker #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .kb         (kb_if),
    .user_move  (user_move),
    .fire       (fire),
    .fire_pulse (fire_pulse),
    .left_held  (left_held),
    .right_held (right_held)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: held keys plus pending prefix flags.
  logic m_left, m_right, m_fire, m_dir, m_ext, m_brk, m_rise;
  int   pulses;
  logic [1:0] early_move;

  function automatic void model_reset();
    m_left = 0; m_right = 0; m_fire = 0; m_dir = 0; m_ext = 0; m_brk = 0; m_rise = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic mk;
    m_rise = 0;
    if (b == 8'hF0 || b == 8'hE0) begin
      if (m_brk) begin m_brk = 0; m_ext = 0; end
      else if (b == 8'hF0) m_brk = 1;
      else m_ext = 1;
    end else begin
      mk = !m_brk;
      if ((m_ext && b == 8'h6B) || (!m_ext && b == 8'h1C)) begin
        m_left = mk; if (mk) m_dir = 0;
      end
      if ((m_ext && b == 8'h74) || (!m_ext && b == 8'h23)) begin
        m_right = mk; if (mk) m_dir = 1;
      end
      if (!m_ext && b == 8'h29) begin
        if (mk && !m_fire) m_rise = 1;
        m_fire = mk;
      end
      m_ext = 0; m_brk = 0;
    end
  endfunction

  function automatic logic [1:0] model_move();
    if (m_left && m_right) return m_dir ? 2'b01 : 2'b10;
    if (m_left)  return 2'b10;
    if (m_right) return 2'b01;
    return 2'b00;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); kb_if.data = b; kb_if.valid = 1'b1;
    @(negedge clk); kb_if.valid = 1'b0; pulses = int'(fire_pulse); early_move = user_move;
    @(negedge clk); pulses += int'(fire_pulse);
    @(negedge clk); pulses += int'(fire_pulse);
    model_byte(b);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; kb_if.valid = 1'b0; kb_if.data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    total++; if (user_move !== 2'b00) begin bad++; $display("FAIL reset_move got=%b want=00", user_move); end
    total++; if (fire !== 1'b0) begin bad++; $display("FAIL reset_fire got=%b want=0", fire); end
    total++; if (fire_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b want=0", fire_pulse); end
    total++; if ({left_held, right_held} !== 2'b00) begin bad++; $display("FAIL reset_held got=%b want=00", {left_held, right_held}); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    send_byte(8'h1C);
    total++; if (early_move !== 2'b00) begin bad++; $display("FAIL basic_latency got=%b want=00", early_move); end
    total++; if (user_move !== 2'b10) begin bad++; $display("FAIL basic_make_move got=%b want=10", user_move); end
    total++; if (left_held !== 1'b1) begin bad++; $display("FAIL basic_make_left got=%b want=1", left_held); end
    send_byte(8'hF0); send_byte(8'h1C);
    total++; if (user_move !== 2'b00) begin bad++; $display("FAIL basic_break_move got=%b want=00", user_move); end
    total++; if (left_held !== 1'b0) begin bad++; $display("FAIL basic_break_left got=%b want=0", left_held); end
  endtask

  task automatic test_last_wins();
    send_byte(8'h1C); send_byte(8'h23);
    total++; if (user_move !== 2'b01) begin bad++; $display("FAIL last_wins_right got=%b want=01", user_move); end
    send_byte(8'h1C);
    total++; if (user_move !== 2'b10) begin bad++; $display("FAIL last_wins_repeat got=%b want=10", user_move); end
    send_byte(8'h23); send_byte(8'hF0); send_byte(8'h23);
    total++; if (user_move !== 2'b10) begin bad++; $display("FAIL last_wins_after_break got=%b want=10", user_move); end
    send_byte(8'hF0); send_byte(8'h1C);
  endtask

  task automatic test_fire();
    int sum;
    send_byte(8'h29); sum = pulses;
    total++; if (pulses !== 1) begin bad++; $display("FAIL fire_first_pulse got=%0d want=1", pulses); end
    total++; if (fire !== 1'b1) begin bad++; $display("FAIL fire_level got=%b want=1", fire); end
    send_byte(8'h29); sum += pulses;
    send_byte(8'h29); sum += pulses;
    total++; if (fire !== 1'b1) begin bad++; $display("FAIL fire_repeat_level got=%b want=1", fire); end
    send_byte(8'hF0); sum += pulses;
    send_byte(8'h29); sum += pulses;
    total++; if (sum !== 1) begin bad++; $display("FAIL fire_pulse_total got=%0d want=1", sum); end
    total++; if (fire !== 1'b0) begin bad++; $display("FAIL fire_released got=%b want=0", fire); end
  endtask

  task automatic test_extended();
    send_byte(8'hE0); send_byte(8'h6B);
    total++; if (left_held !== 1'b1) begin bad++; $display("FAIL ext_make_left got=%b want=1", left_held); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    total++; if (left_held !== 1'b0) begin bad++; $display("FAIL ext_break_left got=%b want=0", left_held); end
    send_byte(8'h6B);
    total++; if ({left_held, right_held, user_move} !== 4'b0000) begin bad++; $display("FAIL ext_plain_ignored got=%b want=0000", {left_held, right_held, user_move}); end
    send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h74);
    total++; if (right_held !== 1'b1) begin bad++; $display("FAIL ext_double_e0 got=%b want=1", right_held); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
  endtask

  task automatic test_timeout();
    // Short wait: break prefix still pending, so 23 releases right.
    send_byte(8'h23);
    send_byte(8'hF0);
    repeat (T - 10) @(negedge clk);
    send_byte(8'h23);
    total++; if (right_held !== m_right || right_held !== 1'b0) begin bad++; $display("FAIL timeout_not_yet got=%b want=0", right_held); end
    // Full wait: prefix abandoned, 23 becomes a make.
    send_byte(8'hF0);
    repeat (T) @(negedge clk);
    m_brk = 0; m_ext = 0;
    send_byte(8'h23);
    total++; if (user_move !== 2'b01) begin bad++; $display("FAIL timeout_move got=%b want=01", user_move); end
    total++; if (right_held !== 1'b1) begin bad++; $display("FAIL timeout_right got=%b want=1", right_held); end
    send_byte(8'hF0); send_byte(8'h23);
  endtask

  task automatic test_reset_mid();
    send_byte(8'hF0);
    do_reset();
    send_byte(8'h23);
    total++; if (user_move !== 2'b01) begin bad++; $display("FAIL reset_mid_move got=%b want=01", user_move); end
    // valid already high when reset releases counts as one byte.
    @(negedge clk); reset = 1'b1; kb_if.data = 8'h1C; kb_if.valid = 1'b1;
    @(negedge clk); reset = 1'b0; model_reset();
    @(negedge clk);
    total++; if (left_held !== 1'b0) begin bad++; $display("FAIL reset_valid_latency got=%b want=0", left_held); end
    @(negedge clk);
    total++; if (left_held !== 1'b1) begin bad++; $display("FAIL reset_valid_accept got=%b want=1", left_held); end
    kb_if.valid = 1'b0; model_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
  endtask

  task automatic test_held_valid();
    @(negedge clk); kb_if.data = 8'h1C; kb_if.valid = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (user_move !== 2'b10) begin bad++; $display("FAIL held_valid_move got=%b want=10", user_move); end
    repeat (18) @(negedge clk);
    kb_if.valid = 1'b0; model_byte(8'h1C);
    // A long F0 must count once, so the following 1C is a break.
    @(negedge clk); kb_if.data = 8'hF0; kb_if.valid = 1'b1;
    repeat (20) @(negedge clk);
    kb_if.valid = 1'b0; model_byte(8'hF0);
    send_byte(8'h1C);
    total++; if (left_held !== 1'b0) begin bad++; $display("FAIL held_valid_single got=%b want=0", left_held); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0: b = 8'h1C; 1: b = 8'h23; 2: b = 8'h29; 3: b = 8'h6B; 4: b = 8'h74;
        5, 6: b = 8'hF0; 7: b = 8'hE0; default: b = 8'($urandom);
      endcase
      send_byte(b);
      total++; if (user_move !== model_move()) begin bad++; $display("FAIL rand_move[%0d] got=%b want=%b", i, user_move, model_move()); end
      total++; if ({left_held, right_held, fire} !== {m_left, m_right, m_fire}) begin bad++; $display("FAIL rand_held[%0d] got=%b want=%b", i, {left_held, right_held, fire}, {m_left, m_right, m_fire}); end
      total++; if (pulses !== int'(m_rise)) begin bad++; $display("FAIL rand_pulse[%0d] got=%0d want=%0d", i, pulses, m_rise); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_last_wins();
    test_fire();
    test_extended();
    test_timeout();
    test_reset_mid();
    test_held_valid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
